// File: rtl/mmio_uart_tx.sv
// mmio_uart_tx: memory-mapped 8N1 UART transmitter with a small TX FIFO.
// Registers (word offsets in a 16-byte window): TXDATA, STATUS, CTRL, reserved.
module mmio_uart_tx #(
    parameter int               WIDTH        = 32,
    parameter logic [WIDTH-1:0] BASE_ADDR    = 32'h1000_0000,
    parameter int               CLKS_PER_BIT = 16,
    parameter int               FIFO_DEPTH   = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] addr_in,
    input  logic [WIDTH-1:0] data_in,
    input  logic [3:0]       byteen,
    input  logic             mem_read,
    input  logic             mem_write,
    output logic [WIDTH-1:0] data_out,
    output logic             tx,
    output logic             irq
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int BW = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [BW-1:0] BAUD_LOAD = BW'(CLKS_PER_BIT - 1);
    localparam logic [BW-1:0] BAUD_ONE  = BW'(1);
    localparam logic [AW:0]   PTR_ONE   = (AW+1)'(1);
    localparam logic [AW:0]   CNT_FULL  = (AW+1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t           state_q, state_d;
    logic [7:0]       shreg_q, shreg_d;
    logic [BW-1:0]    baud_q, baud_d;
    logic [2:0]       bit_idx_q, bit_idx_d;
    logic             tx_q, tx_d;
    logic [7:0]       mem_q [FIFO_DEPTH];
    logic [7:0]       mem_d [FIFO_DEPTH];
    logic [AW:0]      wr_ptr_q, wr_ptr_d;
    logic [AW:0]      rd_ptr_q, rd_ptr_d;
    logic             overflow_q, overflow_d;
    logic             enable_q, enable_d;
    logic             irq_en_q, irq_en_d;
    logic             irq_q, irq_d;
    logic [WIDTH-1:0] data_out_q, data_out_d;

    logic             sel;
    logic [1:0]       offset;
    logic [AW:0]      count;
    logic             full, empty, busy;
    logic             push, pop, wr_ctrl, rd_status;
    logic [7:0]       head;
    logic [WIDTH-1:0] status_word;
    logic [WIDTH-1:0] ctrl_word;
    logic             unused_bits;

    assign sel         = (addr_in[WIDTH-1:4] == BASE_ADDR[WIDTH-1:4]);
    assign offset      = addr_in[3:2];
    assign count       = wr_ptr_q - rd_ptr_q;
    assign full        = (count == CNT_FULL);
    assign empty       = (count == '0);
    assign busy        = (state_q != IDLE);
    assign head        = mem_q[rd_ptr_q[AW-1:0]];
    assign unused_bits = ^{addr_in[1:0], byteen[3:1], data_in[WIDTH-1:8], BASE_ADDR[3:0]};

    assign data_out = data_out_q;
    assign tx       = tx_q;
    assign irq      = irq_q;

    // Bus decode, register writes and registered read data
    always_comb begin
        push      = sel & mem_write & (offset == 2'd0) & byteen[0];
        wr_ctrl   = sel & mem_write & (offset == 2'd2) & byteen[0];
        rd_status = sel & mem_read  & (offset == 2'd1);

        status_word      = '0;
        status_word[0]   = full;
        status_word[1]   = empty;
        status_word[2]   = busy;
        status_word[3]   = overflow_q;
        status_word[8:4] = 5'(count);

        ctrl_word    = '0;
        ctrl_word[0] = enable_q;
        ctrl_word[1] = irq_en_q;

        enable_d = enable_q;
        irq_en_d = irq_en_q;
        if (wr_ctrl) begin
            enable_d = data_in[0];
            irq_en_d = data_in[1];
        end

        data_out_d = data_out_q;
        if (sel && mem_read) begin
            case (offset)
                2'd1:    data_out_d = status_word;
                2'd2:    data_out_d = ctrl_word;
                default: data_out_d = '0;
            endcase
        end

        // A dropped push on the same edge as a STATUS read leaves overflow set.
        overflow_d = overflow_q;
        if (rd_status)     overflow_d = 1'b0;
        if (push && full)  overflow_d = 1'b1;

        irq_d = irq_en_q & empty & ~busy;
    end

    // FIFO storage and pointer update; pop always wins, push needs pre-edge room
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push && !full) begin
            mem_d[wr_ptr_q[AW-1:0]] = data_in[7:0];
            wr_ptr_d = wr_ptr_q + PTR_ONE;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
        end
    end

    // Transmit FSM next-state, shifter, baud counter and registered tx level
    always_comb begin
        state_d   = state_q;
        shreg_d   = shreg_q;
        baud_d    = baud_q;
        bit_idx_d = bit_idx_q;
        tx_d      = tx_q;
        pop       = 1'b0;
        case (state_q)
            IDLE: begin
                tx_d = 1'b1;
                if (enable_q && !empty) begin
                    pop     = 1'b1;
                    shreg_d = head;
                    baud_d  = BAUD_LOAD;
                    state_d = START;
                    tx_d    = 1'b0;
                end
            end
            START: begin
                if (baud_q == '0) begin
                    state_d   = DATA;
                    baud_d    = BAUD_LOAD;
                    bit_idx_d = '0;
                    tx_d      = shreg_q[0];
                end else begin
                    baud_d = baud_q - BAUD_ONE;
                end
            end
            DATA: begin
                if (baud_q == '0) begin
                    baud_d = BAUD_LOAD;
                    if (bit_idx_q == 3'd7) begin
                        state_d = STOP;
                        tx_d    = 1'b1;
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                        shreg_d   = shreg_q >> 1;
                        tx_d      = shreg_q[1];
                    end
                end else begin
                    baud_d = baud_q - BAUD_ONE;
                end
            end
            STOP: begin
                if (baud_q == '0) begin
                    if (enable_q && !empty) begin
                        pop     = 1'b1;
                        shreg_d = head;
                        baud_d  = BAUD_LOAD;
                        state_d = START;
                        tx_d    = 1'b0;
                    end else begin
                        state_d = IDLE;
                        tx_d    = 1'b1;
                    end
                end else begin
                    baud_d = baud_q - BAUD_ONE;
                end
            end
        endcase
    end

    // FIFO data array, not reset: contents are only meaningful between the pointers
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    // Control/status and FSM registers with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            shreg_q    <= '0;
            baud_q     <= '0;
            bit_idx_q  <= '0;
            tx_q       <= 1'b1;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            overflow_q <= 1'b0;
            enable_q   <= 1'b1;
            irq_en_q   <= 1'b0;
            irq_q      <= 1'b0;
            data_out_q <= '0;
        end else begin
            state_q    <= state_d;
            shreg_q    <= shreg_d;
            baud_q     <= baud_d;
            bit_idx_q  <= bit_idx_d;
            tx_q       <= tx_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            overflow_q <= overflow_d;
            enable_q   <= enable_d;
            irq_en_q   <= irq_en_d;
            irq_q      <= irq_d;
            data_out_q <= data_out_d;
        end
    end

endmodule

// File: tb/tb_mmio_uart_tx.sv
// tb_mmio_uart_tx: directed bench with a serial-line receiver and a byte scoreboard.
module tb_mmio_uart_tx;

    localparam int          CPB   = 4;
    localparam int          DEPTH = 8;
    localparam logic [31:0] BASE  = 32'h1000_0000;
    localparam logic [31:0] TXD   = BASE;
    localparam logic [31:0] STAT  = BASE + 32'h4;
    localparam logic [31:0] CTRL  = BASE + 32'h8;
    localparam logic [31:0] RSV   = BASE + 32'hC;
    localparam logic [31:0] OUTW  = BASE + 32'h10;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] addr_in, data_in, data_out;
    logic [3:0]  byteen;
    logic        mem_read, mem_write, tx, irq;

    always #5 clk = ~clk;

    mmio_uart_tx #(
        .WIDTH       (32),
        .BASE_ADDR   (BASE),
        .CLKS_PER_BIT(CPB),
        .FIFO_DEPTH  (DEPTH)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .addr_in  (addr_in),
        .data_in  (data_in),
        .byteen   (byteen),
        .mem_read (mem_read),
        .mem_write(mem_write),
        .data_out (data_out),
        .tx       (tx),
        .irq      (irq)
    );

    int         tests = 0;
    int         fails = 0;
    int         cyc   = 0;
    logic [7:0] sb[$];
    int         frame_starts[$];
    logic       rx_active = 1'b0;
    int         rx_off;
    int         rx_k;
    logic [7:0] rx_byte;
    logic [31:0] rd;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic bus_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
        addr_in   = a;
        data_in   = d;
        byteen    = be;
        mem_write = 1'b1;
        mem_read  = 1'b0;
        @(negedge clk);
        mem_write = 1'b0;
    endtask

    task automatic bus_read(input logic [31:0] a, output logic [31:0] d);
        addr_in   = a;
        byteen    = 4'hF;
        mem_read  = 1'b1;
        mem_write = 1'b0;
        @(negedge clk);
        mem_read  = 1'b0;
        d = data_out;
    endtask

    task automatic watch_idle(input string tag, input int n, input logic irq_exp);
        logic ok;
        ok = 1'b1;
        repeat (n) begin
            @(negedge clk);
            if (tx !== 1'b1 || irq !== irq_exp) ok = 1'b0;
        end
        chk(tag, 32'(ok), 32'd1);
    endtask

    task automatic wait_drain(input string tag, input int budget);
        int n;
        n = 0;
        while ((sb.size() != 0 || rx_active) && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk(tag, 32'(sb.size()), 32'd0);
    endtask

    // Serial receiver: samples mid-bit on falling clock edges, pops scoreboard at stop bit
    initial begin
        forever begin
            @(negedge clk);
            cyc++;
            if (reset === 1'b1) begin
                rx_active = 1'b0;
            end else if (!rx_active) begin
                if (tx === 1'b0) begin
                    rx_active = 1'b1;
                    rx_off    = 0;
                    frame_starts.push_back(cyc);
                end
            end else begin
                rx_off++;
                if (rx_off == CPB / 2) begin
                    chk("rx_start_bit", 32'(tx), 32'd0);
                end else if (rx_off > CPB / 2 && ((rx_off - CPB / 2) % CPB) == 0) begin
                    rx_k = (rx_off - CPB / 2) / CPB - 1;
                    if (rx_k < 8) begin
                        rx_byte[rx_k] = tx;
                    end else begin
                        chk("rx_stop_bit", 32'(tx), 32'd1);
                        tests++;
                        assert (sb.size() != 0) else begin
                            fails++;
                            $error("FAIL rx_unexpected_frame: observed byte 0x%0h expected no frame", rx_byte);
                        end
                        if (sb.size() != 0) chk("rx_byte", 32'(rx_byte), 32'(sb.pop_front()));
                        rx_active = 1'b0;
                    end
                end
            end
        end
    end

    initial begin
        reset     = 1'b1;
        addr_in   = '0;
        data_in   = '0;
        byteen    = '0;
        mem_read  = 1'b0;
        mem_write = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_tx", 32'(tx), 32'd1);
        chk("reset_irq", 32'(irq), 32'd0);
        chk("reset_data_out", data_out, 32'd0);
        reset = 1'b0;

        // Idle after reset
        watch_idle("idle_100", 100, 1'b0);
        bus_read(STAT, rd);
        chk("status_after_reset", rd, 32'h002);
        bus_write(TXD, 32'h77, 4'b1110);
        bus_read(STAT, rd);
        chk("txdata_be0_ignored", rd, 32'h002);

        // Single frame 0x55: write in cycle N, tx low from N+2 for CPB cycles
        sb.push_back(8'h55);
        bus_write(TXD, 32'h55, 4'b0001);
        chk("frame_tx_high_n1", 32'(tx), 32'd1);
        @(negedge clk);
        chk("frame_tx_low_n2", 32'(tx), 32'd0);
        repeat (3) @(negedge clk);
        chk("frame_tx_low_n5", 32'(tx), 32'd0);
        @(negedge clk);
        chk("frame_bit0_n6", 32'(tx), 32'd1);
        bus_read(STAT, rd);
        chk("status_busy_empty", rd, 32'h006);
        wait_drain("drain_55", 100);
        watch_idle("idle_after_55", 20, 1'b0);

        // Burst of nine, tenth overflows; frames back to back
        frame_starts.delete();
        for (int i = 0; i < 9; i++) begin
            sb.push_back(8'(i));
            bus_write(TXD, 32'(i), 4'b0001);
        end
        bus_write(TXD, 32'h09, 4'b0001);
        bus_read(STAT, rd);
        chk("status_full_overflow", rd, 32'h08D);
        bus_read(STAT, rd);
        chk("status_overflow_cleared", rd, 32'h085);
        wait_drain("drain_burst", 500);
        chk("burst_frame_count", 32'(frame_starts.size()), 32'd9);
        begin
            logic ok;
            ok = 1'b1;
            for (int i = 1; i < frame_starts.size(); i++)
                if (frame_starts[i] - frame_starts[i-1] != 10 * CPB) ok = 1'b0;
            chk("burst_contiguous", 32'(ok), 32'd1);
        end
        watch_idle("idle_after_burst", 10, 1'b0);

        // Disabled transmitter holds the byte; enabling starts it, irq after drain
        bus_write(CTRL, 32'h2, 4'b0001);
        sb.push_back(8'hA5);
        bus_write(TXD, 32'hA5, 4'b0001);
        chk("irq_empty_idle_enabled", 32'(irq), 32'd1);
        watch_idle("disabled_no_tx", 20, 1'b0);
        bus_read(STAT, rd);
        chk("status_disabled_count1", rd, 32'h010);
        bus_write(CTRL, 32'h3, 4'b0001);
        @(negedge clk);
        chk("enable_tx_start", 32'(tx), 32'd0);
        repeat (40) @(negedge clk);
        chk("irq_before_rise", 32'(irq), 32'd0);
        chk("tx_idle_after_a5", 32'(tx), 32'd1);
        @(negedge clk);
        chk("irq_after_drain", 32'(irq), 32'd1);
        bus_write(CTRL, 32'h1, 4'b0001);
        wait_drain("drain_a5", 20);

        // Reset during data bit 3 of 0xC3 (bit3 = 0)
        sb.push_back(8'hC3);
        bus_write(TXD, 32'hC3, 4'b0001);
        repeat (18) @(negedge clk);
        chk("tx_bit3_low", 32'(tx), 32'd0);
        reset = 1'b1;
        @(negedge clk);
        chk("midframe_reset_tx", 32'(tx), 32'd1);
        chk("midframe_reset_data_out", data_out, 32'd0);
        sb.delete();
        @(negedge clk);
        reset = 1'b0;
        bus_read(STAT, rd);
        chk("status_after_midreset", rd, 32'h002);
        bus_read(CTRL, rd);
        chk("ctrl_after_midreset", rd, 32'h001);
        bus_read(RSV, rd);
        chk("reserved_reads_zero", rd, 32'h000);
        watch_idle("no_residual_frame", 60, 1'b0);

        // Out-of-window accesses
        bus_read(TXD, rd);
        chk("txdata_reads_zero", rd, 32'h000);
        bus_write(OUTW, 32'hFF, 4'hF);
        bus_read(OUTW, rd);
        chk("outside_read_zero", rd, 32'h000);
        bus_read(STAT, rd);
        chk("outside_fifo_unchanged", rd, 32'h002);
        watch_idle("outside_tx_idle", 60, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
